// File: rtl/wall_array_ctrl.sv
// wall_array_ctrl
// Drives NUM_WALLS independent scrolling walls through one shared req/ack port into the
// pixel draw engine. Once per movement tick a scheduler walks every wall in index order.
// For each wall it erases the old image, applies one state step, then redraws the wall.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   go         per-wall spawn request (edge latched)
//   touched    per-wall collision flag (edge latched)
//   draw_ack   draw engine accepts the current command
//   draw_req   command valid
//   draw_erase 1 = paint background, 0 = paint wall
//   draw_id    wall index of the command
//   draw_x     column of the command
//   active     wall is in MOVE or STOP
//   hit        one-cycle pulse when a wall enters STOP
//   busy       scheduler is sweeping (not waiting for a tick)
module wall_array_ctrl #(
    parameter int unsigned NUM_WALLS = 4,
    parameter int unsigned X_WIDTH   = 8,
    parameter int unsigned X_START   = 159,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned STEP      = 1,
    parameter int unsigned TICK_DIV  = 833333,
    parameter int unsigned ID_W      = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WALLS-1:0] go,
    input  logic [NUM_WALLS-1:0] touched,
    input  logic                 draw_ack,
    output logic                 draw_req,
    output logic                 draw_erase,
    output logic [ID_W-1:0]      draw_id,
    output logic [X_WIDTH-1:0]   draw_x,
    output logic [NUM_WALLS-1:0] active,
    output logic [NUM_WALLS-1:0] hit,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [X_WIDTH-1:0] X_START_C = X_WIDTH'(X_START);
    localparam logic [X_WIDTH-1:0] STEP_C    = X_WIDTH'(STEP);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_WALLS - 1);
    // Compared in 32 bits so X_MIN+STEP cannot wrap at X_WIDTH.
    localparam int unsigned RETIRE_LIM = X_MIN + STEP;

    typedef enum logic [2:0] {S_WAIT, S_ERASE, S_STEP, S_DRAW, S_NEXT} sched_e;
    typedef enum logic [1:0] {W_READY, W_MOVE, W_STOP} wall_e;

    sched_e               fsm_q, fsm_d;
    logic [ID_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tick_pend_q, tick_pend_d;
    logic [NUM_WALLS-1:0] go_pend_q, go_pend_d;
    logic [NUM_WALLS-1:0] touch_pend_q, touch_pend_d;
    logic [NUM_WALLS-1:0] go_prev_q, go_prev_d;
    logic [NUM_WALLS-1:0] touch_prev_q, touch_prev_d;
    logic [NUM_WALLS-1:0] hit_q, hit_d;
    wall_e                st_q [NUM_WALLS];
    wall_e                st_d [NUM_WALLS];
    logic [X_WIDTH-1:0]   pos_q [NUM_WALLS];
    logic [X_WIDTH-1:0]   pos_d [NUM_WALLS];

    logic                 tick;
    logic                 vis_cur;
    logic [NUM_WALLS-1:0] clr;

    assign tick    = (cnt_q == CNT_LAST);
    assign vis_cur = (st_q[idx_q] != W_READY);

    always_comb begin
        fsm_d        = fsm_q;
        idx_d        = idx_q;
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        tick_pend_d  = tick_pend_q;
        go_prev_d    = go;
        touch_prev_d = touched;
        hit_d        = '0;
        clr          = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            st_d[i]  = st_q[i];
            pos_d[i] = pos_q[i];
        end

        // One-deep overrun memory: extra ticks during the same sweep are dropped.
        if (tick && fsm_q != S_WAIT) begin
            tick_pend_d = 1'b1;
        end

        unique case (fsm_q)
            S_WAIT: begin
                if (tick || tick_pend_q) begin
                    fsm_d       = S_ERASE;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end
            end
            S_ERASE: begin
                if (!vis_cur || draw_ack) begin
                    fsm_d = S_STEP;
                end
            end
            S_STEP: begin
                clr[idx_q] = 1'b1;
                fsm_d      = S_DRAW;
                unique case (st_q[idx_q])
                    W_READY: begin
                        if (go_pend_q[idx_q]) begin
                            st_d[idx_q]  = W_MOVE;
                            pos_d[idx_q] = X_START_C;
                        end
                    end
                    W_MOVE: begin
                        if (touch_pend_q[idx_q]) begin
                            st_d[idx_q]  = W_STOP;
                            hit_d[idx_q] = 1'b1;
                        end else if (32'(pos_q[idx_q]) < RETIRE_LIM) begin
                            st_d[idx_q] = W_READY;
                        end else begin
                            pos_d[idx_q] = pos_q[idx_q] - STEP_C;
                        end
                    end
                    default: st_d[idx_q] = W_READY;
                endcase
            end
            S_DRAW: begin
                if (!vis_cur || draw_ack) begin
                    fsm_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_ID) begin
                    fsm_d = S_WAIT;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                    fsm_d = S_ERASE;
                end
            end
            default: fsm_d = S_WAIT;
        endcase

        // Set wins over clear so an edge arriving during this wall's step is not lost.
        go_pend_d    = (go_pend_q & ~clr) | (go & ~go_prev_q);
        touch_pend_d = (touch_pend_q & ~clr) | (touched & ~touch_prev_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= S_WAIT;
            idx_q        <= '0;
            cnt_q        <= '0;
            tick_pend_q  <= 1'b0;
            go_pend_q    <= '0;
            touch_pend_q <= '0;
            go_prev_q    <= '0;
            touch_prev_q <= '0;
            hit_q        <= '0;
            for (int i = 0; i < NUM_WALLS; i++) begin
                st_q[i]  <= W_READY;
                pos_q[i] <= X_START_C;
            end
        end else begin
            fsm_q        <= fsm_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tick_pend_q  <= tick_pend_d;
            go_pend_q    <= go_pend_d;
            touch_pend_q <= touch_pend_d;
            go_prev_q    <= go_prev_d;
            touch_prev_q <= touch_prev_d;
            hit_q        <= hit_d;
            for (int i = 0; i < NUM_WALLS; i++) begin
                st_q[i]  <= st_d[i];
                pos_q[i] <= pos_d[i];
            end
        end
    end

    // Command fields decode from registered state only; zeroed when no command is offered.
    always_comb begin
        draw_req   = ((fsm_q == S_ERASE) || (fsm_q == S_DRAW)) && vis_cur;
        draw_erase = (fsm_q == S_ERASE) && vis_cur;
        draw_id    = draw_req ? idx_q : '0;
        draw_x     = draw_req ? pos_q[idx_q] : '0;
        busy       = (fsm_q != S_WAIT);
        hit        = hit_q;
        for (int i = 0; i < NUM_WALLS; i++) begin
            active[i] = (st_q[i] != W_READY);
        end
    end

endmodule

// File: tb/tb_wall_array_ctrl.sv
// Self-checking bench for wall_array_ctrl: directed table, hand-written corner sequences
// (retire, ack stall, tick overrun, asynchronous reset) and randomized sweeps against a
// per-sweep reference model of the wall rules.
module tb_wall_array_ctrl;

    localparam int NW     = 4;
    localparam int XS     = 21;
    localparam int XMIN   = 0;
    localparam int STP    = 2;
    localparam int TDIV   = 40;
    localparam int SWEEP  = 4 * NW;

    typedef struct packed {
        logic       erase;
        logic [1:0] id;
        logic [7:0] x;
    } cmd_t;

    typedef struct {
        logic [3:0] go;
        logic [3:0] touched;
        int         n;
        cmd_t       cmds [5];
        logic [3:0] hit;
        logic [3:0] active;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NW-1:0] go = '0;
    logic [NW-1:0] touched = '0;
    logic          draw_ack = 1'b1;
    logic          draw_req;
    logic          draw_erase;
    logic [1:0]    draw_id;
    logic [7:0]    draw_x;
    logic [NW-1:0] active;
    logic [NW-1:0] hit;
    logic          busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    cmd_t obs_q [$];
    cmd_t exp_q [$];
    logic [3:0] hit_mask;
    int   hit_total;
    int   sweep_cycles;
    int   start_wait;

    // Reference model state: 0 = ready, 1 = moving, 2 = stopped.
    int         m_st  [NW];
    int         m_pos [NW];
    logic [3:0] m_gp;
    logic [3:0] m_tp;
    logic [3:0] m_hit;

    vec_t tbl [6];

    wall_array_ctrl #(
        .NUM_WALLS(NW),
        .X_WIDTH  (8),
        .X_START  (XS),
        .X_MIN    (XMIN),
        .STEP     (STP),
        .TICK_DIV (TDIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .touched   (touched),
        .draw_ack  (draw_ack),
        .draw_req  (draw_req),
        .draw_erase(draw_erase),
        .draw_id   (draw_id),
        .draw_x    (draw_x),
        .active    (active),
        .hit       (hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cmd_t mk(input logic e, input int id, input int x);
        cmd_t c;
        c.erase = e;
        c.id    = id[1:0];
        c.x     = x[7:0];
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        go = '0;
        touched = '0;
        draw_ack = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < NW; w++) begin
            m_st[w]  = 0;
            m_pos[w] = XS;
        end
        m_gp = '0;
        m_tp = '0;
    endtask

    task automatic pulse(input logic [3:0] g, input logic [3:0] t);
        go = g;
        touched = t;
        @(negedge clk);
        go = '0;
        touched = '0;
    endtask

    // Captures one full sweep at negedges. Optionally holds draw_ack low for stall_n cycles
    // starting at the first offered command, checking the command stays stable meanwhile.
    task automatic run_sweep(input int stall_n, input bit rand_ack);
        int   guard = 0;
        bit   stall_started = 0;
        int   stall_left = 0;
        cmd_t hold;
        cmd_t cur;
        obs_q.delete();
        hit_mask = '0;
        hit_total = 0;
        sweep_cycles = 0;
        start_wait = 0;
        while (!busy && guard < 300) begin
            @(negedge clk);
            guard++;
            start_wait++;
        end
        chk("sweep_start", {31'd0, busy}, 32'd1);
        guard = 0;
        while (busy && guard < 2000) begin
            cur = mk(draw_erase, int'(draw_id), int'(draw_x));
            if (stall_n > 0 && !stall_started && draw_req) begin
                stall_started = 1;
                stall_left = stall_n;
                hold = cur;
            end else if (stall_left > 0) begin
                chk("stall_stable", {21'd0, cur}, {21'd0, hold});
                chk("stall_req", {31'd0, draw_req}, 32'd1);
            end
            if (stall_left > 0) begin
                draw_ack = 1'b0;
                stall_left--;
            end else begin
                draw_ack = rand_ack ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (draw_req && draw_ack) obs_q.push_back(cur);
            hit_mask |= hit;
            hit_total += $countones(hit);
            sweep_cycles++;
            @(negedge clk);
            guard++;
        end
        chk("sweep_end", {31'd0, busy}, 32'd0);
        draw_ack = 1'b1;
    endtask

    task automatic check_sweep(input string name, input logic [3:0] exp_hit,
                               input logic [3:0] exp_act);
        chk($sformatf("%s_ncmd", name), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_cmd%0d", name, i), {21'd0, obs_q[i]}, {21'd0, exp_q[i]});
        end
        chk($sformatf("%s_hit", name), {28'd0, hit_mask}, {28'd0, exp_hit});
        chk($sformatf("%s_hitlen", name), hit_total, $countones(exp_hit));
        chk($sformatf("%s_active", name), {28'd0, active}, {28'd0, exp_act});
    endtask

    // One sweep of the wall rules applied to the model; fills exp_q and m_hit.
    task automatic model_sweep();
        exp_q.delete();
        m_hit = '0;
        for (int w = 0; w < NW; w++) begin
            if (m_st[w] != 0) exp_q.push_back(mk(1'b1, w, m_pos[w]));
            if (m_st[w] == 0) begin
                if (m_gp[w]) begin
                    m_st[w]  = 1;
                    m_pos[w] = XS;
                end
            end else if (m_st[w] == 1) begin
                if (m_tp[w]) begin
                    m_st[w] = 2;
                    m_hit[w] = 1'b1;
                end else if (m_pos[w] < XMIN + STP) begin
                    m_st[w] = 0;
                end else begin
                    m_pos[w] = m_pos[w] - STP;
                end
            end else begin
                m_st[w] = 0;
            end
            m_gp[w] = 1'b0;
            m_tp[w] = 1'b0;
            if (m_st[w] != 0) exp_q.push_back(mk(1'b0, w, m_pos[w]));
        end
    endtask

    function automatic logic [3:0] model_active();
        logic [3:0] a;
        for (int w = 0; w < NW; w++) a[w] = (m_st[w] != 0);
        return a;
    endfunction

    initial begin
        // Directed table, applied in order from reset.
        tbl[0].go = 4'b0001; tbl[0].touched = 4'b0000; tbl[0].n = 1;
        tbl[0].cmds[0] = mk(0, 0, 21);
        tbl[0].hit = 4'b0000; tbl[0].active = 4'b0001;
        tbl[1].go = 4'b0000; tbl[1].touched = 4'b0000; tbl[1].n = 2;
        tbl[1].cmds[0] = mk(1, 0, 21); tbl[1].cmds[1] = mk(0, 0, 19);
        tbl[1].hit = 4'b0000; tbl[1].active = 4'b0001;
        tbl[2].go = 4'b0000; tbl[2].touched = 4'b0001; tbl[2].n = 2;
        tbl[2].cmds[0] = mk(1, 0, 19); tbl[2].cmds[1] = mk(0, 0, 19);
        tbl[2].hit = 4'b0001; tbl[2].active = 4'b0001;
        tbl[3].go = 4'b0000; tbl[3].touched = 4'b0000; tbl[3].n = 1;
        tbl[3].cmds[0] = mk(1, 0, 19);
        tbl[3].hit = 4'b0000; tbl[3].active = 4'b0000;
        tbl[4].go = 4'b0011; tbl[4].touched = 4'b0010; tbl[4].n = 2;
        tbl[4].cmds[0] = mk(0, 0, 21); tbl[4].cmds[1] = mk(0, 1, 21);
        tbl[4].hit = 4'b0000; tbl[4].active = 4'b0011;
        tbl[5].go = 4'b0100; tbl[5].touched = 4'b0001; tbl[5].n = 5;
        tbl[5].cmds[0] = mk(1, 0, 21); tbl[5].cmds[1] = mk(0, 0, 21);
        tbl[5].cmds[2] = mk(1, 1, 21); tbl[5].cmds[3] = mk(0, 1, 19);
        tbl[5].cmds[4] = mk(0, 2, 21);
        tbl[5].hit = 4'b0001; tbl[5].active = 4'b0111;

        // Reset values, observed while reset is held.
        #3;
        chk("rst_req", {31'd0, draw_req}, 32'd0);
        chk("rst_erase", {31'd0, draw_erase}, 32'd0);
        chk("rst_id", {30'd0, draw_id}, 32'd0);
        chk("rst_x", {24'd0, draw_x}, 32'd0);
        chk("rst_active", {28'd0, active}, 32'd0);
        chk("rst_hit", {28'd0, hit}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        do_reset();

        for (int k = 0; k < 6; k++) begin
            pulse(tbl[k].go, tbl[k].touched);
            run_sweep(0, 1'b0);
            exp_q.delete();
            for (int c = 0; c < tbl[k].n; c++) exp_q.push_back(tbl[k].cmds[c]);
            check_sweep($sformatf("tbl%0d", k), tbl[k].hit, tbl[k].active);
            chk($sformatf("tbl%0d_cycles", k), sweep_cycles, SWEEP);
        end

        // Retire: 21,19,...,1 then retire at 1 and respawn at X_START.
        do_reset();
        pulse(4'b0001, 4'b0000);
        for (int k = 1; k <= 13; k++) begin
            run_sweep(0, 1'b0);
            exp_q.delete();
            if (k == 1 || k == 13) begin
                exp_q.push_back(mk(0, 0, XS));
            end else if (k == 12) begin
                exp_q.push_back(mk(1, 0, 1));
            end else begin
                exp_q.push_back(mk(1, 0, XS - STP * (k - 2)));
                exp_q.push_back(mk(0, 0, XS - STP * (k - 1)));
            end
            if (k == 1 || k >= 11) begin
                check_sweep($sformatf("retire%0d", k), 4'b0000, (k == 12) ? 4'b0000 : 4'b0001);
            end
            if (k == 12) pulse(4'b0001, 4'b0000);
        end

        // Ack stall of 5 cycles during a draw, then a long stall spanning two ticks.
        do_reset();
        pulse(4'b0001, 4'b0000);
        run_sweep(5, 1'b0);
        exp_q.delete();
        exp_q.push_back(mk(0, 0, XS));
        check_sweep("stall", 4'b0000, 4'b0001);
        chk("stall_cycles", sweep_cycles, SWEEP + 5);

        run_sweep(70, 1'b0);
        exp_q.delete();
        exp_q.push_back(mk(1, 0, XS));
        exp_q.push_back(mk(0, 0, XS - STP));
        check_sweep("overrun", 4'b0000, 4'b0001);
        chk("overrun_cycles", sweep_cycles, SWEEP + 70);
        run_sweep(0, 1'b0);
        chk("overrun_restart", {31'd0, (start_wait <= 1)}, 32'd1);
        exp_q.delete();
        exp_q.push_back(mk(1, 0, XS - STP));
        exp_q.push_back(mk(0, 0, XS - 2 * STP));
        check_sweep("extra", 4'b0000, 4'b0001);
        begin
            int busy_cnt = 0;
            repeat (10) begin
                @(negedge clk);
                busy_cnt += int'(busy);
            end
            chk("no_second_extra", busy_cnt, 0);
        end

        // Asynchronous reset while a command is being offered.
        do_reset();
        pulse(4'b0001, 4'b0000);
        draw_ack = 1'b0;
        begin
            int guard = 0;
            while (!draw_req && guard < 300) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("pre_reset_req", {31'd0, draw_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_req", {31'd0, draw_req}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_active", {28'd0, active}, 32'd0);
        do_reset();
        pulse(4'b0000, 4'b0000);
        run_sweep(0, 1'b0);
        exp_q.delete();
        check_sweep("post_reset", 4'b0000, 4'b0000);
        chk("post_reset_cycles", sweep_cycles, SWEEP);

        // Randomized sweeps with random ack stalls against the model.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            logic [3:0] g;
            logic [3:0] t;
            g = 4'($urandom_range(15) & $urandom_range(15));
            t = 4'($urandom_range(15) & $urandom_range(15));
            m_gp |= g;
            m_tp |= t;
            pulse(g, t);
            run_sweep(0, 1'b1);
            model_sweep();
            check_sweep($sformatf("rand%0d", r), m_hit, model_active());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
